// File: rtl/down_count_arbiter.sv
// Two requesters share one down counter through a round-robin grant.
// The owner's countdown runs to zero, then a one-cycle done pulse is raised for that owner.
module down_count_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [WIDTH-1:0] q,
   output logic             done0,
   output logic             done1
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q;
   logic             owner_q;
   logic             last_q;
   logic [WIDTH-1:0] q_q;

   logic winner_c;
   logic own_req_c;

   // On a tie the requester that was not granted last wins.
   assign winner_c  = (req0 & req1) ? ~last_q : req1;
   assign own_req_c = owner_q ? req1 : req0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         q_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  owner_q <= winner_c;
                  last_q  <= winner_c;
                  q_q     <= winner_c ? len1 : len0;
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               // An owner dropping its request aborts without a done pulse.
               if (!own_req_c) begin
                  state_q <= IDLE;
                  q_q     <= '0;
               end else if (q_q != '0) begin
                  q_q <= q_q - WIDTH'(1);
               end else begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               q_q     <= '0;
            end
            default: begin
               state_q <= IDLE;
               q_q     <= '0;
            end
         endcase
      end
   end

   // Outputs are plain decodes of registered state.
   assign busy  = (state_q == COUNT) | (state_q == DONE);
   assign gnt0  = busy & ~owner_q;
   assign gnt1  = busy & owner_q;
   assign done0 = (state_q == DONE) & ~owner_q;
   assign done1 = (state_q == DONE) & owner_q;
   assign q     = q_q;

endmodule

// File: doc/down_count_arbiter.md
# down_count_arbiter

Shares one WIDTH-bit down counter between two requesters. Each requester asks for a countdown of a given length. A round-robin arbiter grants the counter to one requester at a time. The block runs the countdown to zero and then pulses a per-requester done. It sits between the block-level control logic and the down-counter datapath, and owns the counter's load, decrement and clear sequencing.

## Interface
- WIDTH, 4, counter and length width in bits
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 countdown request (level)
- len0  input  WIDTH  requester 0 countdown length; sampled only at grant
- req1  input  1  requester 1 countdown request (level)
- len1  input  WIDTH  requester 1 countdown length; sampled only at grant
- gnt0  output  1  counter owned by requester 0
- gnt1  output  1  counter owned by requester 1
- busy  output  1  state is COUNT or DONE
- q  output  WIDTH  current counter value
- done0  output  1  one-cycle pulse: requester 0 countdown reached zero
- done1  output  1  one-cycle pulse: requester 1 countdown reached zero

## Operation
- Registered state: state (IDLE/COUNT/DONE), owner (1 bit), last (1 bit, last granted), q.
- All outputs are decoded from registered state; there are no combinational input-to-output paths.
  - gnt0 = busy & owner==0; gnt1 = busy & owner==1.
  - done0/done1 = state==DONE & matching owner.
- IDLE:
  - q = 0.
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not `last`.
  - On grant: owner <= winner, last <= winner, q <= len of winner, state <= COUNT.
- COUNT:
  - Owner's req low: abort. state <= IDLE, q <= 0, no done pulse, `last` keeps the aborted owner.
  - Else if q != 0: q <= q - 1.
  - Else (q == 0): state <= DONE.
  - The other requester's req is ignored.
- DONE:
  - Lasts exactly one cycle, then state <= IDLE and q stays 0.
  - Requests are not arbitrated in DONE.
- Arithmetic: q only decrements in COUNT with q != 0. It never wraps below 0; 0 - 1 never occurs.
- Requesters must deassert req in the cycle done is seen if they do not want a repeat grant. A req still high in IDLE is granted again, subject to round-robin.
- Reset (rst low, any time, including mid-countdown):
  - state = IDLE, q = 0, owner = 0, last = 1.
  - gnt0 = gnt1 = busy = done0 = done1 = 0.
  - After reset, a tie is won by requester 0.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt, busy and q = len visible after edge N.
- Countdown: q = len, len-1, ..., 0, one value per cycle. DONE follows the cycle where q = 0.
- Grant duration: len + 2 cycles. This covers len+1 COUNT cycles plus one DONE cycle. len = 0 gives 2 cycles.
- Done pulse: len + 1 cycles after the grant edge, 1 cycle wide, coincident with the final gnt cycle.
- Turnaround: DONE -> IDLE -> next grant. There is at least one idle cycle with gnt0 = gnt1 = 0 between consecutive grants.
- Abort: owner's req low at edge M gives gnt = 0, busy = 0, q = 0 after edge M.
- len changes after grant have no effect.

## Test plan
- Reset then single request: rst released, req0=1, len0=3 -> q: 3,2,1,0 over 4 cycles. done0 pulses in the 5th cycle with gnt0 high. gnt0 drops the next cycle. done1 and gnt1 stay 0.
- Tie arbitration: req0=req1=1 held, len0=2, len1=1 -> grants alternate 0,1,0,1. Each grant is separated by one idle cycle and each has the correct q sequence and matching done pulse.
- Zero length: req1=1, len1=0 -> q=0 for one COUNT cycle, done1 on the next cycle, grant duration 2 cycles.
- Abort: req0=1, len0=9, drop req0 when q=5 -> next cycle gnt0=0, busy=0, q=0, no done0. A waiting req1 is granted on the following IDLE cycle.
- Reset mid-operation: assert rst low asynchronously while q=4 under gnt1 -> immediately q=0 and all outputs 0. After release with both requests high, requester 0 wins.
- Max length: WIDTH=4, len0=15 -> 15 decrements with no wrap. done0 comes 16 cycles after the grant edge.
